// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: MEM-stage FSM encodings and data-memory timeout defaults.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  localparam int unsigned MEM_TIMEOUT_DEF = 16;

  // Counter width for a wait limit; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// REQ-phase wait counter; expired is high while the count sits at TIMEOUT-1.
module mem_timeout_cnt
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired_c = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: IDLE -> REQ -> DONE over a req/ack port, stalling the pipeline.
// Optional REQ timeout (mem_err) is built when MEM_TIMEOUT_EN is defined.
module mem_access_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
`ifdef MEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEF
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead_MEM,
  input  logic              MemWrite_MEM,
  input  logic [ADDR_W-1:0] ALU_OUT_MEM,
  input  logic [DATA_W-1:0] REG2_DATA_MEM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall_mem,
  output logic [DATA_W-1:0] rdata_mem,
  output logic              rdata_valid,
  output logic              mem_err
);

  mem_state_e r_state;
  mem_state_e w_next;

  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rdata_valid;

  logic w_start;
  logic w_in_req;
  logic w_ack;
  logic w_timeout;

  assign w_start  = (r_state == ST_IDLE) & (MemRead_MEM | MemWrite_MEM);
  assign w_in_req = (r_state == ST_REQ);
  assign w_ack    = w_in_req & dmem_ack;

`ifdef MEM_TIMEOUT_EN
  logic w_expired;
  logic r_mem_err;

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (w_start),
    .i_en        (w_in_req & ~dmem_ack),
    .o_expired_c (w_expired)
  );

  // A same-cycle ack beats the timeout.
  assign w_timeout = w_in_req & ~dmem_ack & w_expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_err <= 1'b0;
    end else begin
      r_mem_err <= w_timeout;
    end
  end

  assign mem_err = r_mem_err;
`else
  assign w_timeout = 1'b0;
  assign mem_err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_next = ST_REQ;
      ST_REQ:  if (w_ack || w_timeout) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Memory-port and result registers; acks outside REQ never reach here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req         <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_rdata_valid <= 1'b0;
      if (w_start) begin
        r_req   <= 1'b1;
        r_we    <= MemWrite_MEM;
        r_addr  <= ALU_OUT_MEM;
        r_wdata <= REG2_DATA_MEM;
      end
      if (w_ack) begin
        r_req         <= 1'b0;
        r_rdata_valid <= 1'b1;
        if (!r_we) begin
          r_rdata <= dmem_rdata;
        end
      end else if (w_timeout) begin
        r_req         <= 1'b0;
        r_rdata       <= '0;
        r_rdata_valid <= 1'b1;
      end
    end
  end

  assign stall_mem   = w_start | w_in_req;
  assign dmem_req    = r_req;
  assign dmem_we     = r_we;
  assign dmem_addr   = r_addr;
  assign dmem_wdata  = r_wdata;
  assign rdata_mem   = r_rdata;
  assign rdata_valid = r_rdata_valid;

endmodule
